// File: rtl/cnn_result_streamer_pkg.sv
// Shared constants and FSM encoding for the simpleCNN result streamer.
package cnn_result_streamer_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned PROB_W      = 113;
    localparam int unsigned WORD_W      = 32;
    localparam logic [7:0]  HDR_MAGIC   = 8'hA5;

    // Words per score, frame length and width of the sign-extended score.
    localparam int unsigned WPP       = (PROB_W + WORD_W - 1) / WORD_W;
    localparam int unsigned FRAME_LEN = 1 + NUM_CLASSES * WPP;
    localparam int unsigned EXT_W     = WPP * WORD_W;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CLS_W = idx_w(NUM_CLASSES);
    localparam int unsigned WRD_W = idx_w(WPP);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StPay  = 2'd2
    } state_e;

endpackage

// File: rtl/cnn_result_streamer.sv
// Snapshots a simpleCNN result on the rising edge of fc_done and streams it as one
// frame: a header word followed by every class score, sign-extended and sent MSW first.
module cnn_result_streamer
    import cnn_result_streamer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fc_done,
    input  logic [3:0]                    result,
    input  logic [15:0]                   count,
    input  logic [NUM_CLASSES*PROB_W-1:0] prob_flat,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          overrun,
    output logic [15:0]                   frames_sent
);

    state_e                        state_q, state_d;
    logic                          fc_done_q, fc_done_d;
    logic                          overrun_q, overrun_d;
    logic [15:0]                   frames_sent_q, frames_sent_d;
    logic [CLS_W-1:0]              cls_q, cls_d;
    logic [WRD_W-1:0]              wrd_q, wrd_d;

    // Snapshot registers: loaded only on an accepted trigger.
    logic [3:0]                    result_s_q, result_s_d;
    logic [15:0]                   count_s_q, count_s_d;
    logic [NUM_CLASSES*PROB_W-1:0] prob_s_q, prob_s_d;

    logic                          trigger;
    logic                          cls_end;
    logic                          wrd_end;
    int unsigned                   cls_base;
    int unsigned                   word_base;
    logic [WRD_W-1:0]              word_sel;
    logic [PROB_W-1:0]             score;
    logic [EXT_W-1:0]              score_ext;
    logic [WORD_W-1:0]             pay_word;

    // Select the current payload word: score cls, word wrd counted from the MSW.
    always_comb begin
        cls_base  = 32'(cls_q) * PROB_W;
        score     = prob_s_q[cls_base +: PROB_W];
        score_ext = {{(EXT_W - PROB_W){score[PROB_W-1]}}, score};
        word_sel  = WRD_W'(WPP - 1) - wrd_q;
        word_base = 32'(word_sel) * WORD_W;
        pay_word  = score_ext[word_base +: WORD_W];
        cls_end   = (cls_q == CLS_W'(NUM_CLASSES - 1));
        wrd_end   = (wrd_q == WRD_W'(WPP - 1));
    end

    // FSM next-state, counters, snapshot capture and stream outputs.
    always_comb begin
        state_d       = state_q;
        fc_done_d     = fc_done;
        overrun_d     = overrun_q;
        frames_sent_d = frames_sent_q;
        cls_d         = cls_q;
        wrd_d         = wrd_q;
        result_s_d    = result_s_q;
        count_s_d     = count_s_q;
        prob_s_d      = prob_s_q;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        m_data        = '0;

        trigger = fc_done & ~fc_done_q;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    result_s_d = result;
                    count_s_d  = count;
                    prob_s_d   = prob_flat;
                    state_d    = StHdr;
                end
            end
            StHdr: begin
                m_valid = 1'b1;
                m_data  = {HDR_MAGIC, 4'h0, result_s_q, count_s_q};
                if (m_ready) begin
                    state_d = StPay;
                    cls_d   = '0;
                    wrd_d   = '0;
                end
            end
            StPay: begin
                m_valid = 1'b1;
                m_data  = pay_word;
                m_last  = cls_end & wrd_end;
                if (m_ready) begin
                    if (cls_end && wrd_end) begin
                        state_d       = StIdle;
                        frames_sent_d = frames_sent_q + 16'd1;
                    end else if (wrd_end) begin
                        wrd_d = '0;
                        cls_d = cls_q + 1'b1;
                    end else begin
                        wrd_d = wrd_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any trigger outside IDLE is lost, including one on the final handshake.
        if (trigger && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            fc_done_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frames_sent_q <= 16'd0;
            cls_q         <= '0;
            wrd_q         <= '0;
        end else begin
            state_q       <= state_d;
            fc_done_q     <= fc_done_d;
            overrun_q     <= overrun_d;
            frames_sent_q <= frames_sent_d;
            cls_q         <= cls_d;
            wrd_q         <= wrd_d;
        end
    end

    // Snapshot data path; contents are only observed while a frame is in flight.
    always_ff @(posedge clk) begin
        result_s_q <= result_s_d;
        count_s_q  <= count_s_d;
        prob_s_q   <= prob_s_d;
    end

    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Bench for cnn_result_streamer: queue-based frame model plus literal spot checks.
module tb_cnn_result_streamer;

    localparam int NC = 10;
    localparam int PW = 113;
    localparam int FL = 41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             fc_done;
    logic [3:0]       result;
    logic [15:0]      count;
    logic [NC*PW-1:0] prob_flat;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_valid;
    logic             m_last;
    logic             busy;
    logic             overrun;
    logic [15:0]      frames_sent;

    cnn_result_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .fc_done     (fc_done),
        .result      (result),
        .count       (count),
        .prob_flat   (prob_flat),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .overrun     (overrun),
        .frames_sent (frames_sent)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: queue of words still owed to the stream, sticky overrun, frame count.
    logic [31:0] mq[$];
    bit          m_ovr;
    logic [15:0] m_frames;
    bit          m_prev_done;

    // Words actually accepted by the stream (recorded by the bench).
    logic [31:0] got[$];
    bit          got_last[$];
    logic [31:0] ref1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference behaviour, evaluated on each rising edge from the bench's own inputs.
    always @(posedge clk) begin
        bit                 was_busy;
        bit                 trig;
        logic signed [PW-1:0]  p;
        logic signed [127:0]   e;
        logic [31:0]        dummy;
        if (rst) begin
            mq.delete();
            m_ovr       = 1'b0;
            m_frames    = 16'd0;
            m_prev_done = 1'b0;
        end else begin
            was_busy = (mq.size() > 0);
            trig     = fc_done && !m_prev_done;
            if (was_busy && m_ready) begin
                dummy = mq.pop_front();
                if (mq.size() == 0) m_frames = m_frames + 16'd1;
            end
            if (trig) begin
                if (was_busy) begin
                    m_ovr = 1'b1;
                end else begin
                    mq.push_back({8'hA5, 4'h0, result, count});
                    for (int k = 0; k < NC; k++) begin
                        p = prob_flat[k*PW +: PW];
                        e = p;
                        for (int w = 0; w < 4; w++) mq.push_back(e[127 - 32*w -: 32]);
                    end
                end
            end
            m_prev_done = fc_done;
        end
    end

    // Per-cycle comparison against the model, and capture of accepted words.
    always @(negedge clk) begin
        if (chk_en) begin
            if (mq.size() > 0) begin
                chk("m_valid", {31'd0, m_valid}, 32'd1);
                chk("m_data", m_data, mq[0]);
                chk("m_last", {31'd0, m_last}, (mq.size() == 1) ? 32'd1 : 32'd0);
                chk("busy", {31'd0, busy}, 32'd1);
            end else begin
                chk("m_valid_idle", {31'd0, m_valid}, 32'd0);
                chk("m_data_idle", m_data, 32'd0);
                chk("m_last_idle", {31'd0, m_last}, 32'd0);
                chk("busy_idle", {31'd0, busy}, 32'd0);
            end
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            chk("frames_sent", {16'd0, frames_sent}, {16'd0, m_frames});
            if (m_valid === 1'b1 && m_ready === 1'b1 && rst === 1'b0) begin
                got.push_back(m_data);
                got_last.push_back(m_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
    endtask

    task automatic set_prob(input int k, input logic [PW-1:0] v);
        prob_flat[k*PW +: PW] = v;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NC; k++) set_prob(k, PW'(k + 1));
        result = 4'd9;
        count  = 16'h0123;
    endtask

    task automatic randomize_inputs();
        logic [127:0] r;
        for (int k = 0; k < NC; k++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_prob(k, r[PW-1:0]);
        end
        result = 4'($urandom_range(0, 15));
        count  = 16'($urandom());
    endtask

    task automatic wait_frame(input bit rnd_ready);
        int n = 0;
        while (got.size() < FL && n < 2000) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready = 1'b1;
        if (got.size() < FL) begin
            n_total++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", got.size(), FL);
        end
        repeat (2) tick();
    endtask

    task automatic chk_last_only_final();
        int ones = 0;
        foreach (got_last[i]) ones += int'(got_last[i]);
        chk("last_count", ones, 1);
        chk("last_pos", {31'd0, got_last[got_last.size()-1]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        fc_done   = 1'b0;
        m_ready   = 1'b0;
        result    = '0;
        count     = '0;
        prob_flat = '0;
        repeat (2) tick();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_frames", {16'd0, frames_sent}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // Test 1: ramp scores, header one cycle after capture.
        set_ramp();
        m_ready = 1'b1;
        got.delete(); got_last.delete();
        pulse();
        chk("t1_valid_lat", {31'd0, m_valid}, 32'd1);
        chk("t1_hdr_lat", m_data, 32'hA5090123);
        wait_frame(1'b0);
        chk("t1_len", got.size(), FL);
        chk("t1_hdr", got[0], 32'hA5090123);
        chk("t1_s0w0", got[1], 32'h0);
        chk("t1_s0w1", got[2], 32'h0);
        chk("t1_s0w2", got[3], 32'h0);
        chk("t1_s0w3", got[4], 32'h1);
        chk("t1_s9w3", got[40], 32'd10);
        chk_last_only_final();
        chk("t1_frames", {16'd0, frames_sent}, 32'd1);
        ref1 = got;

        // Test 2: negative and positive-maximum scores (2^112-1 has 16 zero bits on top).
        set_prob(3, {PW{1'b1}} - PW'(2'd1));
        set_prob(0, {1'b0, {(PW-1){1'b1}}});
        got.delete(); got_last.delete();
        pulse();
        wait_frame(1'b0);
        chk("t2_p0w0", got[1], 32'h0000FFFF);
        chk("t2_p0w1", got[2], 32'hFFFFFFFF);
        chk("t2_p0w3", got[4], 32'hFFFFFFFF);
        chk("t2_p3w0", got[13], 32'hFFFFFFFF);
        chk("t2_p3w2", got[15], 32'hFFFFFFFF);
        chk("t2_p3w3", got[16], 32'hFFFFFFFE);

        // Test 3: random backpressure yields the same word sequence as test 1.
        set_ramp();
        got.delete(); got_last.delete();
        m_ready = 1'b0;
        pulse();
        wait_frame(1'b1);
        chk("t3_len", got.size(), FL);
        for (int i = 0; i < FL && i < got.size(); i++) chk("t3_word", got[i], ref1[i]);
        chk_last_only_final();

        // Test 4: held level triggers once; triggers while busy are dropped.
        got.delete(); got_last.delete();
        fc_done = 1'b1;
        repeat (100) tick();
        chk("t4_len", got.size(), FL);
        chk("t4_frames", {16'd0, frames_sent}, 32'd4);
        chk("t4_ovr0", {31'd0, overrun}, 32'd0);
        fc_done = 1'b0;
        tick();
        got.delete(); got_last.delete();
        pulse();
        repeat (10) tick();
        chk("t4_ovr_pre", {31'd0, overrun}, 32'd0);
        pulse();
        tick();
        chk("t4_ovr_mid", {31'd0, overrun}, 32'd1);
        n = 0;
        while (!(m_valid === 1'b1 && m_last === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("t4_saw_last", {31'd0, m_last}, 32'd1);
        pulse();
        repeat (3) tick();
        chk("t4_no_new_frame", {31'd0, m_valid}, 32'd0);
        chk("t4_frames2", {16'd0, frames_sent}, 32'd5);
        chk("t4_len2", got.size(), FL);
        chk("t4_ovr_end", {31'd0, overrun}, 32'd1);

        // Test 5: reset mid-frame aborts; next trigger yields a fresh full frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ovr_clr", {31'd0, overrun}, 32'd0);
        result = 4'h3;
        count  = 16'hBEEF;
        got.delete(); got_last.delete();
        pulse();
        n = 0;
        while (got.size() < 20 && n < 200) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_frames", {16'd0, frames_sent}, 32'd0);
        repeat (3) tick();
        chk("t5_no_resume", {31'd0, m_valid}, 32'd0);
        got.delete(); got_last.delete();
        pulse();
        wait_frame(1'b0);
        chk("t5_len", got.size(), FL);
        chk("t5_hdr", got[0], 32'hA503BEEF);
        chk("t5_frames2", {16'd0, frames_sent}, 32'd1);

        // Random phase: random data, backpressure and trigger pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) randomize_inputs();
            m_ready = 1'($urandom_range(0, 1));
            fc_done = ($urandom_range(0, 19) == 0);
            tick();
        end
        fc_done = 1'b0;
        m_ready = 1'b1;
        repeat (60) tick();

        // Test 6: frame counter wraps from 16'hFFFF to 0.
        force dut.frames_sent_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        tick();
        release dut.frames_sent_q;
        tick();
        chk("t6_preload", {16'd0, frames_sent}, 32'h0000FFFF);
        got.delete(); got_last.delete();
        pulse();
        wait_frame(1'b0);
        chk("t6_wrap", {16'd0, frames_sent}, 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
